// File: rtl/fence_sequencer_pkg.sv
// fence_sequencer_pkg: shared types for the memory-ordering / fence logic.
//   FlushFlag_t  - flush-target flags used by the cache/TLB maintenance paths
//   FenceType_t  - serialising request type carried on IN_reqType
package fence_sequencer_pkg;

    localparam int unsigned FENCE_TYPE_W = 2;
    localparam int unsigned QUIET_CNT_W  = 4;

    typedef enum logic [1:0] {
        FLUSH_NONE   = 2'd0,
        FLUSH_DCACHE = 2'd1,
        FLUSH_ICACHE = 2'd2,
        FLUSH_TLB    = 2'd3
    } FlushFlag_t;

    typedef enum logic [FENCE_TYPE_W-1:0] {
        FT_ORDERING   = 2'd0,
        FT_FENCE      = 2'd1,
        FT_FENCE_I    = 2'd2,
        FT_SFENCE_VMA = 2'd3
    } FenceType_t;

endpackage

// File: rtl/fence_sequencer_quiet_counter.sv
// quiet_counter: counts consecutive quiet cycles while enabled, saturating at
// QUIET_CYCLES; any non-quiet enabled cycle restarts the count.
//   clk, rst  - clock, synchronous active-high reset
//   en        - count only while set (sequencer in DRAIN)
//   quiet     - store queue empty and memory idle this cycle
//   clear     - restart count (new request accepted)
//   reached   - registered: count has reached QUIET_CYCLES
module quiet_counter
    import fence_sequencer_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic quiet,
    input  logic clear,
    output logic reached
);

    localparam logic [QUIET_CNT_W-1:0] TARGET = QUIET_CNT_W'(QUIET_CYCLES);

    logic [QUIET_CNT_W-1:0] count;
    logic [QUIET_CNT_W-1:0] countNext;

    // Next count: clear wins, then restart on noise, else saturating increment.
    always_comb begin
        countNext = count;
        if (clear) begin
            countNext = '0;
        end else if (en) begin
            if (!quiet) begin
                countNext = '0;
            end else if (count != TARGET) begin
                countNext = count + QUIET_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            reached <= 1'b0;
        end else begin
            count   <= countNext;
            reached <= (countNext == TARGET);
        end
    end

endmodule

// File: rtl/fence_sequencer.sv
// fence_sequencer: sequences serialising instructions (ORDERING, FENCE,
// FENCE_I, SFENCE_VMA): drain memory, optional D$ writeback, I$ invalidate or
// TLB flush, then a one-cycle completion pulse.
// Optional feature macro: FENCE_I_DCFLUSH_EN (adds D$ writeback before I$ inval).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   IN_reqValid, IN_reqType        request strobe and type (FenceType_t)
//   OUT_ready                      idle, request will be accepted
//   IN_sqEmpty, IN_memBusy         drain status
//   OUT_dcFlushReq, IN_dcFlushAck  D$ writeback handshake (level / pulse)
//   OUT_icInval                    I$ invalidate pulse
//   OUT_tlbFlush, IN_tlbFlushDone  TLB flush pulse / completion pulse
//   OUT_disableIFetch              hold instruction fetch
//   OUT_done, OUT_doneType         completion pulse and its type
module fence_sequencer
    import fence_sequencer_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    IN_reqValid,
    input  logic [FENCE_TYPE_W-1:0] IN_reqType,
    output logic                    OUT_ready,
    input  logic                    IN_sqEmpty,
    input  logic                    IN_memBusy,
    output logic                    OUT_dcFlushReq,
    input  logic                    IN_dcFlushAck,
    output logic                    OUT_icInval,
    output logic                    OUT_tlbFlush,
    input  logic                    IN_tlbFlushDone,
    output logic                    OUT_disableIFetch,
    output logic                    OUT_done,
    output logic [FENCE_TYPE_W-1:0] OUT_doneType
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAIN   = 3'd1;
`ifdef FENCE_I_DCFLUSH_EN
    localparam logic [2:0] DCFLUSH = 3'd2;
`endif
    localparam logic [2:0] ICINV   = 3'd3;
    localparam logic [2:0] TLBWAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0] state;
    logic [2:0] stateNext;
    FenceType_t reqType;
    logic       reqAccept;
    logic       quietReached;
    logic       holdFetch;

    assign reqAccept = (state == IDLE) && IN_reqValid;

    quiet_counter #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quietCounter (
        .clk    (clk),
        .rst    (rst),
        .en     (state == DRAIN),
        .quiet  (IN_sqEmpty && !IN_memBusy),
        .clear  (reqAccept),
        .reached(quietReached)
    );

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (IN_reqValid) stateNext = DRAIN;
            end
            DRAIN: begin
                if (quietReached) begin
                    case (reqType)
`ifdef FENCE_I_DCFLUSH_EN
                        FT_FENCE_I:    stateNext = DCFLUSH;
`else
                        FT_FENCE_I:    stateNext = ICINV;
`endif
                        FT_SFENCE_VMA: stateNext = TLBWAIT;
                        default:       stateNext = DONE;
                    endcase
                end
            end
`ifdef FENCE_I_DCFLUSH_EN
            DCFLUSH: begin
                if (IN_dcFlushAck) stateNext = ICINV;
            end
`endif
            ICINV:   stateNext = DONE;
            TLBWAIT: begin
                if (IN_tlbFlushDone) stateNext = DONE;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, latched type and outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            reqType      <= FT_ORDERING;
            OUT_ready    <= 1'b1;
            OUT_icInval  <= 1'b0;
            OUT_tlbFlush <= 1'b0;
            OUT_done     <= 1'b0;
            OUT_doneType <= '0;
            holdFetch    <= 1'b0;
        end else begin
            state        <= stateNext;
            if (reqAccept) reqType <= FenceType_t'(IN_reqType);
            OUT_ready    <= (stateNext == IDLE);
            OUT_icInval  <= (stateNext == ICINV);
            OUT_tlbFlush <= (stateNext == TLBWAIT) && (state != TLBWAIT);
            OUT_done     <= (stateNext == DONE);
            OUT_doneType <= (stateNext == DONE) ? FENCE_TYPE_W'(reqType) : '0;
            holdFetch    <= (stateNext != IDLE);
        end
    end

    // Fetch must stop in the very cycle the request is presented.
    assign OUT_disableIFetch = holdFetch || (reqAccept && !rst);

`ifdef FENCE_I_DCFLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) OUT_dcFlushReq <= 1'b0;
        else     OUT_dcFlushReq <= (stateNext == DCFLUSH);
    end
`else
    logic unusedDcFlushAck;
    assign unusedDcFlushAck = IN_dcFlushAck;
    assign OUT_dcFlushReq   = 1'b0;
`endif

endmodule

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: randomized self-checking bench for fence_sequencer.
// Each sequence is precomputed as per-cycle input arrays; expected event
// cycles come from the drain/handshake rules applied to those arrays.
module tb_fence_sequencer;

    localparam int unsigned Q = 2;
    localparam int N = 48;

    logic       clk;
    logic       rst;
    logic       IN_reqValid;
    logic [1:0] IN_reqType;
    logic       OUT_ready;
    logic       IN_sqEmpty;
    logic       IN_memBusy;
    logic       OUT_dcFlushReq;
    logic       IN_dcFlushAck;
    logic       OUT_icInval;
    logic       OUT_tlbFlush;
    logic       IN_tlbFlushDone;
    logic       OUT_disableIFetch;
    logic       OUT_done;
    logic [1:0] OUT_doneType;

    int nChecks = 0;
    int nPass   = 0;

    bit busyA [N];
    bit emptyA[N];
    bit ackA  [N];
    bit tdA   [N];
    bit reqA  [N];

    fence_sequencer #(.QUIET_CYCLES(Q)) dut (
        .clk              (clk),
        .rst              (rst),
        .IN_reqValid      (IN_reqValid),
        .IN_reqType       (IN_reqType),
        .OUT_ready        (OUT_ready),
        .IN_sqEmpty       (IN_sqEmpty),
        .IN_memBusy       (IN_memBusy),
        .OUT_dcFlushReq   (OUT_dcFlushReq),
        .IN_dcFlushAck    (IN_dcFlushAck),
        .OUT_icInval      (OUT_icInval),
        .OUT_tlbFlush     (OUT_tlbFlush),
        .IN_tlbFlushDone  (IN_tlbFlushDone),
        .OUT_disableIFetch(OUT_disableIFetch),
        .OUT_done         (OUT_done),
        .OUT_doneType     (OUT_doneType)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
        nChecks++;
        if (got == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic checkIdle(input string tag);
        checkEq({tag, " ready"},   OUT_ready, 1);
        checkEq({tag, " dcReq"},   OUT_dcFlushReq, 0);
        checkEq({tag, " icInval"}, OUT_icInval, 0);
        checkEq({tag, " tlb"},     OUT_tlbFlush, 0);
        checkEq({tag, " fetch"},   OUT_disableIFetch, 0);
        checkEq({tag, " done"},    OUT_done, 0);
        checkEq({tag, " type"},    OUT_doneType, 0);
    endtask

    task automatic driveIdle();
        IN_reqValid = 0; IN_reqType = 0; IN_sqEmpty = 1; IN_memBusy = 0;
        IN_dcFlushAck = 0; IN_tlbFlushDone = 0;
    endtask

    // One request of type t. noise: random drain noise for k cycles and stray
    // acks/flush-done pulses; pat20 uses the fixed busy pattern 1,0,1,0,0.
    task automatic runSeq(input int t, input bit noise, input int k,
                          input int ackDelay, input int tlbDelay, input bit pat20);
        int d, endC, dcLo, dcHi, ic, tlb, w, obsDone;
        bit ok, found;
        bit [4:0] pat;
        pat = 5'b00101;  // bit i -> cycle i+1
        for (int c = 0; c < N; c++) begin
            busyA[c]  = 0;
            emptyA[c] = 1;
            ackA[c]   = noise && ($urandom_range(0, 4) == 0);
            tdA[c]    = noise && ($urandom_range(0, 4) == 0);
            reqA[c]   = (c > 0) && ($urandom_range(0, 3) == 0);
        end
        reqA[0] = 1;
        if (noise) begin
            for (int c = 0; c <= k; c++) begin
                busyA[c]  = ($urandom_range(0, 1) == 1);
                emptyA[c] = ($urandom_range(0, 2) != 0);
            end
        end
        if (pat20) for (int c = 1; c <= 5; c++) busyA[c] = pat[c-1];

        // Drain ends in the first cycle preceded by Q quiet DRAIN cycles.
        d = 0;
        for (int c = Q + 1; c < N && d == 0; c++) begin
            ok = 1;
            for (int j = c - Q; j < c; j++) if (busyA[j] || !emptyA[j]) ok = 0;
            if (ok) d = c;
        end
        dcLo = -1; dcHi = -1; ic = -1; tlb = -1;
        case (t)
            2: begin
`ifdef FENCE_I_DCFLUSH_EN
                dcLo = d + 1;
                ackA[d + 1 + ackDelay] = 1;
                found = 0;
                for (int c = d + 1; c < N && !found; c++)
                    if (ackA[c]) begin dcHi = c; found = 1; end
                ic = dcHi + 1;
`else
                ic = d + 1;
`endif
                endC = ic + 1;
            end
            3: begin
                tlb = d + 1;
                tdA[d + 1 + tlbDelay] = 1;
                w = -1; found = 0;
                for (int c = d + 1; c < N && !found; c++)
                    if (tdA[c]) begin w = c; found = 1; end
                endC = w + 1;
            end
            default: endC = d + 1;
        endcase
        for (int c = endC + 1; c < N; c++) reqA[c] = 0;

        obsDone = -1;
        for (int c = 0; c <= endC + 1; c++) begin
            @(posedge clk); #1;
            IN_reqValid     = reqA[c];
            IN_reqType      = (c == 0) ? 2'(t) : 2'($urandom_range(0, 3));
            IN_sqEmpty      = emptyA[c];
            IN_memBusy      = busyA[c];
            IN_dcFlushAck   = ackA[c];
            IN_tlbFlushDone = tdA[c];
            @(negedge clk);
            if (OUT_done && obsDone < 0) obsDone = c;
            checkEq($sformatf("t%0d c%0d ready", t, c), OUT_ready, (c == 0 || c > endC) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d fetch", t, c), OUT_disableIFetch, (c <= endC) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d dcReq", t, c), OUT_dcFlushReq,
                    (dcLo >= 0 && c >= dcLo && c <= dcHi) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d icInval", t, c), OUT_icInval, (c == ic) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d tlb", t, c), OUT_tlbFlush, (c == tlb) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d done", t, c), OUT_done, (c == endC) ? 1 : 0);
            checkEq($sformatf("t%0d c%0d type", t, c), OUT_doneType, (c == endC) ? t : 0);
        end
        checkEq($sformatf("t%0d doneCycle", t), obsDone, endC);
        @(posedge clk); #1;
        driveIdle();
    endtask

    // Reset while mid-sequence, then stray handshakes must be ignored.
    task automatic runResetMid();
        @(posedge clk); #1;
`ifdef FENCE_I_DCFLUSH_EN
        IN_reqType = 2'd2;
`else
        IN_reqType = 2'd3;
`endif
        IN_reqValid = 1; IN_sqEmpty = 1; IN_memBusy = 0;
        IN_dcFlushAck = 0; IN_tlbFlushDone = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            IN_reqValid = 0;
        end
        @(negedge clk);
        checkEq("rstMid busyBefore", OUT_disableIFetch, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checkIdle("rstMid after");
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            IN_dcFlushAck = 1; IN_tlbFlushDone = 1;
            @(negedge clk);
            checkIdle($sformatf("rstMid stray%0d", c));
        end
        @(posedge clk); #1;
        driveIdle();
    endtask

    initial begin
        rst = 1;
        driveIdle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checkIdle("postReset");

        runSeq(1, 0, 0, 0, 0, 0);  // FENCE, always quiet
        runSeq(0, 0, 0, 0, 0, 1);  // ORDERING, memBusy 1,0,1,0,0
        runSeq(2, 0, 0, 4, 0, 0);  // FENCE_I, ack on fifth dcFlushReq cycle
        runSeq(3, 0, 0, 0, 0, 0);  // SFENCE_VMA, done with the flush pulse
        runSeq(3, 0, 0, 3, 6, 0);
        runResetMid();
        runSeq(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            runSeq(int'($urandom_range(0, 3)), 1, int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fence_sequencer.md
FENCE_SEQUENCER -- requirements
Module: fence_sequencer

Interface
REQ-001 SHALL have parameter QUIET_CYCLES, default 2: number of consecutive quiet cycles required before drain completes (range 1..15).
REQ-002 SHALL have ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
IN_reqValid  in  1  serialising instruction committed
IN_reqType  in  2  0=ORDERING, 1=FENCE, 2=FENCE_I, 3=SFENCE_VMA
OUT_ready  out  1  idle, can accept request
IN_sqEmpty  in  1  store queue empty
IN_memBusy  in  1  memory subsystem has outstanding ops
OUT_dcFlushReq  out  1  D$ writeback request (level)
IN_dcFlushAck  in  1  D$ writeback complete (pulse)
OUT_icInval  out  1  I$ invalidate (1-cycle pulse)
OUT_tlbFlush  out  1  TLB flush (1-cycle pulse)
IN_tlbFlushDone  in  1  TLB flush complete (pulse)
OUT_disableIFetch  out  1  hold instruction fetch
OUT_done  out  1  sequence complete (1-cycle pulse)
OUT_doneType  out  2  type of completed sequence

Function
REQ-003 SHALL implement states IDLE, DRAIN, DCFLUSH, ICINV, TLBWAIT, DONE.
REQ-004 SHALL assert OUT_ready only in IDLE; IN_reqValid with OUT_ready=0 SHALL be ignored.
REQ-005 IDLE + IN_reqValid SHALL latch IN_reqType and enter DRAIN next cycle, clearing the quiet counter.
REQ-006 DRAIN: quiet counter SHALL increment (saturating at QUIET_CYCLES) each cycle IN_sqEmpty=1 and IN_memBusy=0, and SHALL clear to 0 on any other cycle.
REQ-007 DRAIN exit when counter reaches QUIET_CYCLES: ORDERING/FENCE -> DONE; FENCE_I -> DCFLUSH (macro set) or ICINV (macro clear); SFENCE_VMA -> TLBWAIT.
REQ-008 DCFLUSH SHALL hold OUT_dcFlushReq=1 until the cycle IN_dcFlushAck=1, then enter ICINV; ack outside DCFLUSH SHALL be ignored.
REQ-009 ICINV SHALL last exactly one cycle with OUT_icInval=1, then enter DONE.
REQ-010 TLBWAIT SHALL pulse OUT_tlbFlush on its first cycle only, remain until IN_tlbFlushDone=1 (accepted even on the first cycle), then enter DONE.
REQ-011 DONE SHALL last one cycle with OUT_done=1, OUT_doneType=latched type, then return to IDLE.
REQ-012 OUT_disableIFetch SHALL be 1 in every state except IDLE, and combinationally 1 in IDLE the cycle IN_reqValid=1.
REQ-013 Minimum latency request->OUT_done SHALL be QUIET_CYCLES+2 cycles for ORDERING/FENCE.
REQ-014 OUT_doneType SHALL be 0 when OUT_done=0.

Reset
REQ-015 rst SHALL force IDLE, clear counter and latched type, and drive all outputs 0 except OUT_ready=1, at any state including mid-sequence; no pulse SHALL be emitted in the reset cycle.

Configuration
REQ-016 Macro FENCE_I_DCFLUSH_EN: defined -> FENCE_I runs DRAIN->DCFLUSH->ICINV->DONE; undefined -> DCFLUSH state absent, OUT_dcFlushReq tied 0, IN_dcFlushAck unused, FENCE_I runs DRAIN->ICINV->DONE.

Structure
REQ-017 Request-type enum (FenceType_t) SHALL reside in the shared package alongside existing flag enums; state enum SHALL be module-local.
REQ-018 Quiet counter SHALL be a sub-module quiet_counter (inputs en, quiet, clear; output reached).

Verification
REQ-019 FENCE, sqEmpty=1, memBusy=0 constant, QUIET_CYCLES=2 -> OUT_done pulse 4 cycles after request, doneType=1, no icInval/tlbFlush.
REQ-020 ORDERING with memBusy toggling 1,0,1,0,0 -> counter resets on each busy cycle; OUT_done 2 cycles after last busy->quiet transition plus DONE cycle.
REQ-021 FENCE_I with macro, ack 5 cycles after dcFlushReq rises -> dcFlushReq high exactly 5 cycles, one icInval pulse next cycle, then done, doneType=2.
REQ-022 SFENCE_VMA, tlbFlushDone same cycle as tlbFlush -> one tlbFlush pulse, done next cycle, doneType=3.
REQ-023 rst asserted while in DCFLUSH -> next cycle IDLE, OUT_ready=1, all request/pulse outputs 0, later stray dcFlushAck ignored.
REQ-024 Second IN_reqValid while OUT_ready=0 -> ignored, exactly one OUT_done produced.
